// File: rtl/word_unload_shl_reg_pkg.sv
// Shared definitions for the word-unload shift register.
// Holds default geometry (word width, word count) and the unload FSM
// state enumeration used by the controller.
package word_unload_shl_reg_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int NWORDS_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNLOAD = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/word_unload_shl_reg_ctrl.sv
// Unload burst controller: FSM plus word counter.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   ST_IDLE   | no burst; bit shifts and start are accepted
//   ST_UNLOAD | dout_valid high, one word leaves per handshake
//   ST_DONE   | one-cycle done pulse after the last word
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begins a burst (ignored while busy)
//   clr, set       register clear/load; these abort a running burst
//   dout_ready     consumer ready
//   dout_valid     high exactly in ST_UNLOAD
//   busy           high in ST_UNLOAD and ST_DONE
//   done           high exactly in ST_DONE
//   word_hs        a word is accepted this cycle (register shifts by one word)
module word_unload_ctrl
  import word_unload_shl_reg_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clr,
  input  logic set,
  input  logic dout_ready,
  output logic dout_valid,
  output logic busy,
  output logic done,
  output logic word_hs
);

  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort;

  // clr/set outrank the handshake, so they also cancel it in the same cycle
  assign abort = clr | set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end
      end
      ST_UNLOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dout_ready) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dout_valid = (state_q == ST_UNLOAD);
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    word_hs    = (state_q == ST_UNLOAD) && dout_ready && !abort;
  end

endmodule

// File: rtl/word_unload_shl_reg.sv
// Left-shifting register with serial bit load and burst word unload.
// Bits enter at the LSB one per we; a burst then presents the top word
// on dout and shifts one word left per accepted handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   we, bit_in      bit shift (ignored while busy)
//   clr, set        clear to 0 / load value 1 (also abort a burst)
//   start           begin unload burst
//   dout            top word of the register (combinational)
//   dout_valid      word awaiting acceptance
//   dout_ready      consumer accepts dout
//   bit_out         register MSB
//   busy, done      burst in progress / one-cycle completion pulse
module word_unload_shl_reg
  import word_unload_shl_reg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              bit_in,
  input  logic              clr,
  input  logic              set,
  input  logic              start,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              bit_out,
  output logic              busy,
  output logic              done
);

  localparam int REG_W = WORD_W * NWORDS;

  logic [REG_W-1:0] reg_q, reg_d;
  logic             word_hs;

  word_unload_ctrl #(
    .NWORDS(NWORDS)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clr       (clr),
    .set       (set),
    .dout_ready(dout_ready),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done),
    .word_hs   (word_hs)
  );

  always_ff @(posedge clk) begin
    if (rst) reg_q <= '0;
    else     reg_q <= reg_d;
  end

  // Priority clr > set > word unload > bit shift; word_hs already excludes clr/set.
  always_comb begin
    reg_d = reg_q;
    if (clr)                reg_d = '0;
    else if (set)           reg_d = REG_W'(1);
    else if (word_hs)       reg_d = reg_q << WORD_W;
    else if (we && !busy)   reg_d = {reg_q[REG_W-2:0], bit_in};
  end

  assign dout    = reg_q[REG_W-1 -: WORD_W];
  assign bit_out = reg_q[REG_W-1];

endmodule

// File: tb/tb_word_unload_shl_reg.sv
module tb_word_unload_shl_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, bit_in = 1'b0, clr = 1'b0, set = 1'b0, start = 1'b0;
  logic        dout_ready = 1'b0;
  logic [15:0] dout;
  logic        dout_valid, bit_out, busy, done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  word_unload_shl_reg dut (
    .clk(clk), .rst(rst), .we(we), .bit_in(bit_in), .clr(clr), .set(set),
    .start(start), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .bit_out(bit_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: a 256-bit value plus a burst phase and words-taken count.
  logic [255:0] m_r = '0;
  int           m_phase = 0;  // 0 = no burst, 1 = words on offer, 2 = completion pulse
  int           m_taken = 0;
  logic [15:0]  dut_words[$];

  always @(posedge clk) begin
    bit hs;
    if (rst) begin
      m_r = '0; m_phase = 0; m_taken = 0;
    end else begin
      hs = (m_phase == 1) && dout_ready && !clr && !set;
      if (clr)                     m_r = '0;
      else if (set)                m_r = 256'd1;
      else if (hs)                 m_r = m_r * (256'd1 << 16);
      else if (we && m_phase == 0) m_r = m_r * 2 + 256'(bit_in);
      if (m_phase == 0) begin
        if (start) begin m_phase = 1; m_taken = 0; end
      end else if (m_phase == 1) begin
        if (clr || set) m_phase = 0;
        else if (hs) begin
          m_taken++;
          if (m_taken == 16) m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, and log of words the DUT handed over.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", 256'(dout), 256'(m_r[255:240]));
      check("flags", {252'd0, dout_valid, busy, done, bit_out},
            {252'd0, m_phase == 1, m_phase != 0, m_phase == 2, m_r[255]});
      if (!rst && dout_valid && dout_ready && !clr && !set) dut_words.push_back(dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      we = 1'b1; bit_in = w[i];
      tick();
    end
    we = 1'b0; bit_in = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high only before even edges,
  // with we/bit_in/start noise held high throughout the burst.
  task automatic run_burst(input int mode, input int stop_after, output int done_edge);
    done_edge = -1;
    start = 1'b1; dout_ready = (mode == 0);
    tick();
    start = (mode == 1);
    for (int e = 2; e < 80; e++) begin
      if (mode == 1) begin
        dout_ready = (e % 2 == 0); we = 1'b1; bit_in = 1'b1;
      end else dout_ready = 1'b1;
      if (stop_after > 0 && e == stop_after + 2) begin
        rst = 1'b1; dout_ready = 1'b0;
      end
      tick();
      if (done) begin done_edge = e; break; end
      if (stop_after > 0 && e == stop_after + 2) break;
    end
    start = 1'b0; we = 1'b0; bit_in = 1'b0; dout_ready = 1'b0; rst = 1'b0;
    if (stop_after == 0 && done_edge < 0) begin
      errors++;
      $display("FAIL burst_timeout actual=no_done required=done");
    end
  endtask

  initial begin
    int de;
    int n0;
    bit ok;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_dout", 256'(dout), 256'd0);
    check("reset_flags", {dout_valid, busy, done, bit_out}, 4'b0000);

    // Pattern 0xA5 repeated, unloaded with ready held high.
    for (int k = 0; k < 16; k++) shift_word(16'hA5A5);
    check("a5_bit_out", 256'(bit_out), 256'd1);
    n0 = dut_words.size();
    run_burst(0, 0, de);
    tick();
    check("a5_done_edge", 256'(de), 256'd17);
    check("a5_count", 256'(dut_words.size() - n0), 256'd16);
    ok = 1'b1;
    for (int k = n0; k < dut_words.size(); k++) if (dut_words[k] !== 16'hA5A5) ok = 1'b0;
    check("a5_words", 256'(ok), 256'd1);
    check("a5_reg_zero", dut.reg_q, 256'd0);

    // Value 1 via set, then unload: fifteen zero words and a final 0x0001.
    set = 1'b1; tick(); set = 1'b0;
    n0 = dut_words.size();
    run_burst(0, 0, de);
    tick();
    check("set_count", 256'(dut_words.size() - n0), 256'd16);
    check("set_last_word", 256'(dut_words[dut_words.size()-1]), 256'd1);
    check("set_first_word", 256'(dut_words[n0]), 256'd0);

    // Words 1..16 from MSB, ready toggling, with we/start noise during the burst.
    for (int k = 1; k <= 16; k++) shift_word(16'(k));
    n0 = dut_words.size();
    run_burst(1, 0, de);
    tick();
    check("seq_done_edge", 256'(de), 256'd32);
    check("seq_count", 256'(dut_words.size() - n0), 256'd16);
    ok = 1'b1;
    for (int k = 0; k < 16; k++) if (dut_words[n0 + k] !== 16'(k + 1)) ok = 1'b0;
    check("seq_order", 256'(ok), 256'd1);
    check("seq_reg_zero", dut.reg_q, 256'd0);

    // Reset after five words accepted.
    for (int k = 0; k < 16; k++) shift_word(16'h1234);
    n0 = dut_words.size();
    run_burst(0, 5, de);
    check("rst_flags", {dout_valid, busy, done}, 3'b000);
    check("rst_reg_zero", dut.reg_q, 256'd0);
    check("rst_count", 256'(dut_words.size() - n0), 256'd5);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin dout_ready = 1'b1; tick(); if (done || dout_valid) ok = 1'b0; end
    dout_ready = 1'b0;
    check("rst_no_done", 256'(ok), 256'd1);

    // Priority in IDLE: set beats we; clr beats set.
    set = 1'b1; we = 1'b1; bit_in = 1'b1; tick();
    set = 1'b0; we = 1'b0; bit_in = 1'b0;
    check("set_beats_we", dut.reg_q, 256'd1);
    clr = 1'b1; set = 1'b1; tick();
    clr = 1'b0; set = 1'b0;
    check("clr_beats_set", dut.reg_q, 256'd0);

    // bit_out follows the MSB as a single 1 walks up the register.
    set = 1'b1; tick(); set = 1'b0;
    for (int i = 0; i < 254; i++) begin we = 1'b1; tick(); end
    check("walk_254", 256'(bit_out), 256'd0);
    tick();
    check("walk_255", 256'(bit_out), 256'd1);
    tick(); we = 1'b0;
    check("walk_256", 256'(bit_out), 256'd0);

    // Abort by clr mid-burst: no done, register cleared.
    set = 1'b1; tick(); set = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    clr = 1'b1; dout_ready = 1'b1; tick(); clr = 1'b0; dout_ready = 1'b0;
    check("abort_flags", {dout_valid, busy, done}, 3'b000);
    tick();
    check("abort_no_done", 256'(done), 256'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
